// File: rtl/wb_gpio_debounce_pkg.sv
// Shared constants for the Wishbone GPIO/debounce peripheral.
// Register byte offsets are also consumed by the firmware header generator.
package wb_gpio_debounce_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  // Byte offsets of the 4-word register window
  localparam logic [3:0] REG_LED_OFS  = 4'h0;
  localparam logic [3:0] REG_BTN_OFS  = 4'h4;
  localparam logic [3:0] REG_STAT_OFS = 4'h8;
  localparam logic [3:0] REG_IEN_OFS  = 4'hC;

endpackage

// File: rtl/wb_gpio_debounce_if.sv
// Wishbone slave bus bundle for the GPIO peripheral.
//  i_wb_cyc/i_wb_stb/i_wb_we  request qualifiers (master -> slave)
//  i_wb_addr/i_wb_data        byte address and write data
//  o_wb_ack/o_wb_stall        completion and flow control (slave -> master)
//  o_wb_data                  read data, valid with o_wb_ack
interface wb_gpio_debounce_if;
  import wb_gpio_debounce_pkg::*;

  logic             i_wb_cyc;
  logic             i_wb_stb;
  logic             i_wb_we;
  logic [WB_AW-1:0] i_wb_addr;
  logic [WB_DW-1:0] i_wb_data;
  logic             o_wb_ack;
  logic             o_wb_stall;
  logic [WB_DW-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_gpio_debounce_debouncer.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a stability counter.
//  clk, reset  clock and synchronous active-high reset
//  din         raw asynchronous input
//  dout        debounced level, follows din after DEBOUNCE_CYCLES stable cycles
module gpio_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Any cycle where the synchronised input matches dout restarts the count,
  // so glitches shorter than DEBOUNCE_CYCLES never propagate.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        dout  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_gpio_debounce.sv
// Wishbone GPIO peripheral: LED outputs, debounced buttons, W1C rising-edge
// status and a maskable level interrupt.
//  clk, reset  clock and synchronous active-high reset
//  wb          Wishbone slave port (registered ack and read data, stall tied 0)
//  buttons     raw asynchronous button inputs
//  leds        LED drive register
//  irq         |(STAT & IEN), registered
module wb_gpio_debounce
  import wb_gpio_debounce_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
  parameter int unsigned NUM_LEDS        = 8,
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_gpio_debounce_if.slave      wb,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic                   irq
);

  logic [NUM_BUTTONS-1:0] btn_db;
  logic [NUM_BUTTONS-1:0] btn_prev_q;
  logic [NUM_BUTTONS-1:0] stat_q;
  logic [NUM_BUTTONS-1:0] ien_q;
  logic [NUM_BUTTONS-1:0] rise_c;
  logic [NUM_BUTTONS-1:0] stat_vis_c;
  logic                   ack_q;
  logic [WB_DW-1:0]       rdata_q;
  logic                   hit_c;
  logic [WB_DW-1:0]       rdata_c;
  logic                   unused_data_c;

  // One conditioner per button
  for (genvar i = 0; i < int'(NUM_BUTTONS); i++) begin : g_btn
    gpio_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .din   (buttons[i]),
      .dout  (btn_db[i])
    );
  end

  // A new rising edge is reported in STAT the same cycle BTN shows it;
  // it is folded into stat_q at the next edge, where it beats a W1C clear.
  assign rise_c     = btn_db & ~btn_prev_q;
  assign stat_vis_c = stat_q | rise_c;

  // Address decode and read mux; only aligned words of the window hit
  always_comb begin
    hit_c   = 1'b0;
    rdata_c = '0;
    if (wb.i_wb_cyc && wb.i_wb_stb && (wb.i_wb_addr[31:4] == BASE_ADDRESS[31:4])) begin
      case (wb.i_wb_addr[3:0])
        REG_LED_OFS:  begin hit_c = 1'b1; rdata_c = WB_DW'(leds);       end
        REG_BTN_OFS:  begin hit_c = 1'b1; rdata_c = WB_DW'(btn_db);     end
        REG_STAT_OFS: begin hit_c = 1'b1; rdata_c = WB_DW'(stat_vis_c); end
        REG_IEN_OFS:  begin hit_c = 1'b1; rdata_c = WB_DW'(ien_q);      end
        default:      ;
      endcase
    end
  end

  // Register file, bus response and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      leds       <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      btn_prev_q <= '0;
      irq        <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q      <= hit_c;
      btn_prev_q <= btn_db;
      irq        <= |(stat_vis_c & ien_q);
      stat_q     <= stat_vis_c;
      if (hit_c && !wb.i_wb_we) begin
        rdata_q <= rdata_c;
      end
      if (hit_c && wb.i_wb_we) begin
        case (wb.i_wb_addr[3:0])
          REG_LED_OFS:  leds   <= wb.i_wb_data[NUM_LEDS-1:0];
          REG_STAT_OFS: stat_q <= (stat_q & ~wb.i_wb_data[NUM_BUTTONS-1:0]) | rise_c;
          REG_IEN_OFS:  ien_q  <= wb.i_wb_data[NUM_BUTTONS-1:0];
          default:      ;
        endcase
      end
    end
  end

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_data  = rdata_q;
  assign wb.o_wb_stall = 1'b0;

  // Upper write-data bits beyond the register widths carry no meaning
  assign unused_data_c = ^wb.i_wb_data;

endmodule
